// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA AXI4 initiator.
package dma_pkg;

  localparam int MAX_BURST_DEF = 16;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR,
    ST_WDATA,
    ST_WRESP,
    ST_DONE
  } dma_state_e;

  // AXI LEN (beats-1) for the next chunk: min(remain, maxBurst) - 1.
  // Only meaningful for remain >= 1.
  function automatic logic [3:0] burstLenM1(input logic [31:0] remain, input int maxBurst);
    if (remain >= $unsigned(maxBurst)) begin
      return 4'(maxBurst - 1);
    end
    return 4'(remain - 32'd1);
  endfunction

endpackage

// File: rtl/dma_buf.sv
// 16 x 32-bit chunk buffer: one synchronous write port, one asynchronous read port.
module dma_buf
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  raddr_i,
  output logic [31:0] rdata_o
);

  logic [31:0] mem_q [16];

  // Capture read-burst beats; the array is not reset because it is always written before read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dma_master.sv
// AXI4 initiator of the DMA: copies DMALEN words from DMASRC to DMADST in
// read-then-write chunks of up to MAX_BURST beats through a local buffer.
module dma_master
  import dma_pkg::*;
#(
  parameter logic [3:0] MASTER_ID = 4'd2,
  parameter int         MAX_BURST = MAX_BURST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMAEN,
  input  logic [31:0] DMASRC,
  input  logic [31:0] DMADST,
  input  logic [31:0] DMALEN,
  output logic        DMA_DONE,
  output logic        DMA_ERR,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  dma_state_e  state_q, state_d;
  logic [31:0] srcPtr_q, srcPtr_d;
  logic [31:0] dstPtr_q, dstPtr_d;
  logic [31:0] remain_q, remain_d;
  logic [3:0]  lenM1_q, lenM1_d;
  logic [3:0]  beatCnt_q, beatCnt_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic [4:0]  blen;
  logic [31:0] stepBytes;
  logic [31:0] remainNext;
  logic        bErr;
  logic [31:0] bufRdata;
  logic        unusedIds;

  assign blen       = {1'b0, lenM1_q} + 5'd1;
  assign stepBytes  = {25'd0, blen, 2'b00};
  assign remainNext = remain_q - {27'd0, blen};
  assign bErr       = err_q | (BRESP != AXI_RESP_OKAY);
  assign unusedIds  = ^{RID, BID};

  dma_buf u_buf (
    .clk     (clk),
    .we_i    ((state_q == ST_RDATA) && RVALID),
    .waddr_i (beatCnt_q),
    .wdata_i (RDATA),
    .raddr_i (beatCnt_q),
    .rdata_o (bufRdata)
  );

  // State and datapath registers; reset returns to IDLE with all handshakes dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      srcPtr_q  <= '0;
      dstPtr_q  <= '0;
      remain_q  <= '0;
      lenM1_q   <= '0;
      beatCnt_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      srcPtr_q  <= srcPtr_d;
      dstPtr_q  <= dstPtr_d;
      remain_q  <= remain_d;
      lenM1_q   <= lenM1_d;
      beatCnt_q <= beatCnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: sequence each chunk as AR, R beats, AW, W beats, B.
  always_comb begin
    state_d   = state_q;
    srcPtr_d  = srcPtr_q;
    dstPtr_d  = dstPtr_q;
    remain_d  = remain_q;
    lenM1_d   = lenM1_q;
    beatCnt_d = beatCnt_q;
    err_d     = err_q;
    done_d    = done_q;
    case (state_q)
      ST_IDLE: begin
        if (DMAEN) begin
          srcPtr_d  = DMASRC;
          dstPtr_d  = DMADST;
          remain_d  = DMALEN;
          err_d     = 1'b0;
          beatCnt_d = '0;
          if (DMALEN == 32'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RADDR;
            lenM1_d = burstLenM1(DMALEN, MAX_BURST);
          end
        end
      end
      ST_RADDR: begin
        if (ARREADY) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (RVALID) begin
          beatCnt_d = beatCnt_q + 4'd1;
          if (RRESP != AXI_RESP_OKAY) err_d = 1'b1;
          if (RLAST) begin
            beatCnt_d = '0;
            state_d   = ST_WADDR;
          end
        end
      end
      ST_WADDR: begin
        if (AWREADY) state_d = ST_WDATA;
      end
      ST_WDATA: begin
        if (WREADY) begin
          if (beatCnt_q == lenM1_q) begin
            beatCnt_d = '0;
            state_d   = ST_WRESP;
          end else begin
            beatCnt_d = beatCnt_q + 4'd1;
          end
        end
      end
      ST_WRESP: begin
        if (BVALID) begin
          err_d    = bErr;
          srcPtr_d = srcPtr_q + stepBytes;
          dstPtr_d = dstPtr_q + stepBytes;
          remain_d = remainNext;
          if ((remainNext == 32'd0) || bErr) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RADDR;
            lenM1_d = burstLenM1(remainNext, MAX_BURST);
          end
        end
      end
      ST_DONE: begin
        if (!DMAEN) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ARID    = MASTER_ID;
  assign ARADDR  = srcPtr_q;
  assign ARLEN   = lenM1_q;
  assign ARSIZE  = AXI_SIZE_4B;
  assign ARBURST = AXI_BURST_INCR;
  assign ARVALID = (state_q == ST_RADDR);
  assign RREADY  = (state_q == ST_RDATA);
  assign AWID    = MASTER_ID;
  assign AWADDR  = dstPtr_q;
  assign AWLEN   = lenM1_q;
  assign AWSIZE  = AXI_SIZE_4B;
  assign AWBURST = AXI_BURST_INCR;
  assign AWVALID = (state_q == ST_WADDR);
  assign WVALID  = (state_q == ST_WDATA);
  assign WDATA   = WVALID ? bufRdata : 32'd0;
  assign WSTRB   = 4'hF;
  assign WLAST   = WVALID && (beatCnt_q == lenM1_q);
  assign BREADY  = (state_q == ST_WRESP);
  assign DMA_DONE = done_q;
  assign DMA_ERR  = err_q;

endmodule

// File: tb/tb_dma_master.sv
// Self-checking bench for dma_master: table of whole-transfer vectors against
// a behavioural AXI slave, plus hand sequences for LEN=0 and mid-burst reset.
module tb_dma_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        DMAEN;
  logic [31:0] DMASRC, DMADST, DMALEN;
  logic        DMA_DONE, DMA_ERR;
  logic [3:0]  ARID, ARLEN, AWID, AWLEN, RID, BID, WSTRB;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  dma_master dut (
    .clk(clk), .rst(rst), .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST),
    .DMALEN(DMALEN), .DMA_DONE(DMA_DONE), .DMA_ERR(DMA_ERR),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    bit          bp;
    int          errChunk;
    int          expBursts;
    bit          expErr;
    int          expWords;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] curSrc, curDst;
  int          curLen, curErrChunk, curBursts;
  bit          bpOn;
  int          arCount, awCount, bCount;
  bit          rdActive, bPending, bHeld, rHeld;
  logic [31:0] rdAddr, wrAddr;
  int          rdLeft, wrLeft;
  bit          prevArPend, prevAwPend, prevWPend;
  logic [31:0] prevAraddr, prevAwaddr, prevWdata;
  logic [3:0]  prevArlen, prevAwlen;
  logic        prevWlast;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: unexpected event at %0t", name, $time);
  endtask

  function automatic logic [31:0] srcWord(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic rnd();
    return bpOn ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  function automatic logic [3:0] expLenM1(input int idx);
    int rem;
    rem = curLen - 16 * idx;
    return (rem >= 16) ? 4'd15 : 4'(rem - 1);
  endfunction

  task automatic slaveReset();
    ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = 0; RRESP = 0; RID = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
    rdActive = 0; bPending = 0; bHeld = 0; rHeld = 0; rdLeft = 0; wrLeft = 0;
    prevArPend = 0; prevAwPend = 0; prevWPend = 0;
  endtask

  // Behavioural AXI slave, evaluated at each falling edge; stages run from B back to AR
  // so that every channel reacts one cycle after the one feeding it.
  initial begin
    slaveReset();
    forever begin
      @(negedge clk);
      if (!rst) begin
        slaveReset();
      end else begin
        if (bPending) begin
          if (!bHeld) begin
            BVALID = rnd();
            BRESP  = (bCount == curErrChunk) ? 2'b10 : 2'b00;
          end
          if (BVALID && BREADY) begin
            bPending = 0; bHeld = 0; bCount++;
          end else begin
            bHeld = BVALID;
          end
        end else begin
          BVALID = 0; BRESP = 0; bHeld = 0;
        end

        WREADY = rnd();
        if (prevWPend) begin
          checkOutput("w_hold_valid", WVALID, 1);
          checkOutput("w_hold_data", WDATA, prevWdata);
          checkOutput("w_hold_last", WLAST, prevWlast);
        end
        if (WVALID && WREADY) begin
          if (wrLeft == 0) begin
            failNow("w_beat_without_aw");
          end else begin
            checkOutput("wstrb", WSTRB, 4'hF);
            checkOutput("w_last", WLAST, wrLeft == 1);
            mem[wrAddr] = WDATA;
            wrAddr = wrAddr + 32'd4;
            wrLeft--;
            if (wrLeft == 0) bPending = 1;
          end
        end
        prevWPend = WVALID && !WREADY; prevWdata = WDATA; prevWlast = WLAST;

        AWREADY = rnd();
        if (prevAwPend) begin
          checkOutput("aw_hold_valid", AWVALID, 1);
          checkOutput("aw_hold_addr", AWADDR, prevAwaddr);
          checkOutput("aw_hold_len", AWLEN, prevAwlen);
        end
        if (AWVALID && AWREADY) begin
          if (awCount >= curBursts) begin
            failNow("aw_extra_burst");
          end else begin
            checkOutput("awaddr", AWADDR, curDst + 32'(64 * awCount));
            checkOutput("awlen", AWLEN, expLenM1(awCount));
            checkOutput("awid", AWID, 4'd2);
            checkOutput("awsize", AWSIZE, 3'b010);
            checkOutput("awburst", AWBURST, 2'b01);
          end
          wrAddr = AWADDR; wrLeft = int'(AWLEN) + 1; awCount++;
        end
        prevAwPend = AWVALID && !AWREADY; prevAwaddr = AWADDR; prevAwlen = AWLEN;

        if (rdActive) begin
          if (!rHeld) RVALID = rnd();
          if (RVALID) begin
            RDATA = srcWord(rdAddr); RLAST = (rdLeft == 1); RRESP = 2'b00;
          end
          if (RVALID && RREADY) begin
            rdAddr = rdAddr + 32'd4; rdLeft--; rHeld = 0;
            if (rdLeft == 0) rdActive = 0;
          end else begin
            rHeld = RVALID;
          end
        end else begin
          RVALID = 0; RLAST = 0; rHeld = 0;
        end

        ARREADY = rnd();
        if (prevArPend) begin
          checkOutput("ar_hold_valid", ARVALID, 1);
          checkOutput("ar_hold_addr", ARADDR, prevAraddr);
          checkOutput("ar_hold_len", ARLEN, prevArlen);
        end
        if (ARVALID && ARREADY) begin
          if (arCount >= curBursts) begin
            failNow("ar_extra_burst");
          end else begin
            checkOutput("araddr", ARADDR, curSrc + 32'(64 * arCount));
            checkOutput("arlen", ARLEN, expLenM1(arCount));
            checkOutput("arid", ARID, 4'd2);
            checkOutput("arsize", ARSIZE, 3'b010);
            checkOutput("arburst", ARBURST, 2'b01);
          end
          rdActive = 1; rdAddr = ARADDR; rdLeft = int'(ARLEN) + 1; arCount++;
        end
        prevArPend = ARVALID && !ARREADY; prevAraddr = ARADDR; prevArlen = ARLEN;
      end
    end
  end

  task automatic setupExpect(input vec_t v);
    mem.delete();
    curSrc = v.src; curDst = v.dst; curLen = int'(v.len);
    curErrChunk = v.errChunk; curBursts = v.expBursts; bpOn = v.bp;
    arCount = 0; awCount = 0; bCount = 0;
  endtask

  task automatic waitAndCheck(input vec_t v);
    bit seen;
    int bAtDone;
    logic [31:0] a;
    seen = 0; bAtDone = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (DMA_DONE) begin
        seen = 1; bAtDone = bCount;
        break;
      end
    end
    checkOutput("done_seen", seen, 1);
    if (seen) checkOutput("b_count_at_done", bAtDone, v.expBursts);
    checkOutput("ar_count", arCount, v.expBursts);
    checkOutput("aw_count", awCount, v.expBursts);
    checkOutput("dma_err", DMA_ERR, v.expErr);
    checkOutput("words_written", mem.num(), v.expWords);
    for (int i = 0; i < v.expWords; i++) begin
      a = v.dst + 32'(4 * i);
      checkOutput("dst_present", mem.exists(a), 1);
      if (mem.exists(a)) checkOutput("dst_data", mem[a], srcWord(v.src + 32'(4 * i)));
    end
    repeat (3) @(negedge clk);
    checkOutput("done_held", DMA_DONE, 1);
    checkOutput("done_no_arvalid", ARVALID, 0);
    DMAEN = 0;
    repeat (2) @(negedge clk);
    checkOutput("done_clear", DMA_DONE, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    setupExpect(v);
    @(negedge clk);
    DMASRC = v.src; DMADST = v.dst; DMALEN = v.len; DMAEN = 1;
    waitAndCheck(v);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    bit   hit;
    vecs[0] = '{32'h0000_1000, 32'h0000_2000, 32'd4,  1'b0, -1, 1, 1'b0, 4};
    vecs[1] = '{32'h0000_1000, 32'h0000_2000, 32'd20, 1'b0, -1, 2, 1'b0, 20};
    vecs[2] = '{32'h0000_1000, 32'h0000_2000, 32'd7,  1'b1, -1, 1, 1'b0, 7};
    vecs[3] = '{32'h0000_1000, 32'h0000_2000, 32'd32, 1'b0,  0, 1, 1'b1, 16};
    vecs[4] = '{32'h0000_4000, 32'h0000_6000, 32'd16, 1'b1, -1, 1, 1'b0, 16};
    vecs[5] = '{32'h0000_7000, 32'h0000_8000, 32'd33, 1'b1,  1, 2, 1'b1, 32};
    vecs[6] = '{32'hFFFF_FFC0, 32'h0000_5000, 32'd20, 1'b0, -1, 2, 1'b0, 20};

    DMAEN = 0; DMASRC = 0; DMADST = 0; DMALEN = 0;
    curErrChunk = -1; curBursts = 0; bpOn = 0;
    rst = 1;
    #1 rst = 0;
    #2;
    checkOutput("rst_arvalid", ARVALID, 0);
    checkOutput("rst_rready", RREADY, 0);
    checkOutput("rst_awvalid", AWVALID, 0);
    checkOutput("rst_wvalid", WVALID, 0);
    checkOutput("rst_bready", BREADY, 0);
    checkOutput("rst_done", DMA_DONE, 0);
    checkOutput("rst_err", DMA_ERR, 0);
    checkOutput("rst_araddr", ARADDR, 0);
    checkOutput("rst_awaddr", AWADDR, 0);
    checkOutput("rst_arlen", ARLEN, 0);
    checkOutput("rst_awlen", AWLEN, 0);
    checkOutput("rst_wdata", WDATA, 0);
    checkOutput("rst_wlast", WLAST, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1;

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d: src 0x%08h len %0d", i, vecs[i].src, vecs[i].len);
      applyStimulus(vecs[i]);
    end

    // Zero-length transfer completes without any AXI traffic.
    rv = '{32'h0000_1000, 32'h0000_2000, 32'd0, 1'b0, -1, 0, 1'b0, 0};
    setupExpect(rv);
    @(negedge clk);
    DMASRC = rv.src; DMADST = rv.dst; DMALEN = 0; DMAEN = 1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("len0_done", DMA_DONE, 1);
    checkOutput("len0_ar_count", arCount, 0);
    checkOutput("len0_aw_count", awCount, 0);
    DMAEN = 0;
    repeat (2) @(negedge clk);
    checkOutput("len0_done_clear", DMA_DONE, 0);

    // Reset while the second write beat is on the bus, then restart from new addresses.
    rv = '{32'h0000_1000, 32'h0000_2000, 32'd4, 1'b0, -1, 1, 1'b0, 4};
    setupExpect(rv);
    @(negedge clk);
    DMASRC = rv.src; DMADST = rv.dst; DMALEN = rv.len; DMAEN = 1;
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (WVALID && wrLeft == 2) begin
        hit = 1;
        break;
      end
    end
    checkOutput("reset_point_reached", hit, 1);
    checkOutput("beat2_data", WDATA, srcWord(32'h0000_1004));
    rst = 0;
    #1;
    checkOutput("midrst_wvalid", WVALID, 0);
    checkOutput("midrst_done", DMA_DONE, 0);
    checkOutput("midrst_arvalid", ARVALID, 0);
    checkOutput("midrst_awvalid", AWVALID, 0);
    rv = '{32'h0000_3000, 32'h0000_2400, 32'd4, 1'b0, -1, 1, 1'b0, 4};
    DMASRC = rv.src; DMADST = rv.dst; DMALEN = rv.len;
    @(negedge clk);
    setupExpect(rv);
    #2 rst = 1;
    waitAndCheck(rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
